// File: rtl/sine_chan_sched.sv
// sine_chan_sched: time-multiplexes one synchronous sine ROM across NCH phase-accumulator channels.
module sine_chan_sched #(
    parameter int NCH = 4,
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int PW  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NCH-1:0]          ch_en,
    input  logic [NCH*PW-1:0]       incr,
    input  logic [NCH*AW-1:0]       offset,
    input  logic                    clr_ovr,
    output logic [AW-1:0]           rom_addr,
    input  logic [DW-1:0]           rom_dout,
    output logic [DW-1:0]           out_data,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] ptr;
    logic [PW-1:0] acc [NCH];
    logic          slot_en;
    logic [PW-1:0] inc_p;

    // Disabled slots still consume their cycle so return timing stays fixed per slot.
    always_comb begin
        slot_en  = state == SCAN && ch_en[ptr];
        inc_p    = incr[ptr*PW +: PW];
        rom_addr = slot_en ? acc[ptr][PW-1 -: AW] + offset[ptr*AW +: AW] : '0;
    end

    assign busy     = state != IDLE;
    assign out_data = out_valid ? rom_dout : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
        end else begin
            out_valid <= slot_en;
            if (slot_en) begin
                out_ch   <= ptr;
                acc[ptr] <= acc[ptr] + inc_p;
            end
            overrun <= (tick && busy) || (overrun && !clr_ovr);
            case (state)
                IDLE: begin
                    ptr <= '0;
                    if (tick) state <= SCAN;
                end
                SCAN: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == CW'(NCH-1)) state <= DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sine_chan_sched.sv
// tb_sine_chan_sched: directed checks of sweep timing, enables, wrap, overrun and reset.
module tb_sine_chan_sched;
    localparam int NCH = 4, AW = 8, DW = 8, PW = 16;

    logic              clk = 0, rst = 0, tick = 0, clr_ovr = 0;
    logic [NCH-1:0]    ch_en = '1;
    logic [NCH*PW-1:0] incr = '0;
    logic [NCH*AW-1:0] offset = '0;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_dout = '0;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
    logic              out_valid, busy, overrun;

    int         n_chk = 0, n_fail = 0;
    logic       exp_ovr = 0;
    logic [15:0] m_acc [NCH];
    logic [7:0]  e [NCH];

    always #5 clk = ~clk;

    // ROM model: rom[a] = a, one-cycle registered read.
    always_ff @(posedge clk) rom_dout <= rom_addr;

    sine_chan_sched #(.NCH(NCH), .AW(AW), .DW(DW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .ch_en(ch_en), .incr(incr),
        .offset(offset), .clr_ovr(clr_ovr), .rom_addr(rom_addr),
        .rom_dout(rom_dout), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tick in the current cycle (cycle 0), then check cycles 1..6; returns in cycle 6 (IDLE).
    task automatic sweep(input logic [3:0] en, input logic [7:0] d0, d1, d2, d3,
                         input int t2, input int cc);
        logic [7:0] d [4];
        d = '{d0, d1, d2, d3};
        ch_en = en;
        tick = 1;
        step();
        tick = 0;
        for (int c = 1; c <= 6; c++) begin
            tick = (c == t2);
            clr_ovr = (c == cc);
            chk("busy", busy, 32'(c <= 5));
            chk("overrun", overrun, exp_ovr);
            if (c >= 2 && c <= 5 && en[c-2]) begin
                chk("valid", out_valid, 1);
                chk("ch", out_ch, c - 2);
                chk("data", out_data, d[c-2]);
            end else begin
                chk("valid_idle", out_valid, 0);
                chk("data_idle", out_data, 0);
            end
            if (c <= 4 && !en[c-1]) chk("addr_dis", rom_addr, 0);
            if (c <= 5) begin
                exp_ovr = tick ? 1'b1 : clr_ovr ? 1'b0 : exp_ovr;
                step();
            end
        end
        tick = 0;
        clr_ovr = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_addr", rom_addr, 0);
        step();
        step();
        rst = 1;
        exp_ovr = 0;
        step();
    endtask

    initial begin
        #1;
        do_reset();
        incr   = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
        offset = {8'hC0, 8'h80, 8'h40, 8'h00};
        sweep(4'hF, 8'h00, 8'h40, 8'h80, 8'hC0, 0, 0);
        sweep(4'hF, 8'h01, 8'h41, 8'h81, 8'hC1, 0, 0);
        // ch0/ch2 skipped: their accumulators must not advance
        sweep(4'b1010, 8'h00, 8'h42, 8'h00, 8'hC2, 0, 0);
        sweep(4'hF, 8'h02, 8'h43, 8'h82, 8'hC3, 0, 0);
        // reset in cycle 3 of a sweep
        ch_en = 4'hF;
        tick = 1;
        step();
        tick = 0;
        step();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 8'h03);
        step();
        rst = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_addr", rom_addr, 0);
        step();
        chk("mid_rst_valid2", out_valid, 0);
        step();
        rst = 1;
        step();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        // phase wrap on ch0
        incr[15:0]  = 16'h8000;
        offset[7:0] = 8'hFF;
        sweep(4'hF, 8'hFF, 8'h40, 8'h80, 8'hC0, 0, 0);
        sweep(4'hF, 8'h7F, 8'h41, 8'h81, 8'hC1, 0, 0);
        sweep(4'hF, 8'hFF, 8'h42, 8'h82, 8'hC2, 0, 0);
        chk("wrap_no_ovr", overrun, 0);
        // overrun: stray tick in cycle 3, then tick+clear together while busy
        sweep(4'hF, 8'h7F, 8'h43, 8'h83, 8'hC3, 3, 0);
        chk("ovr_set", overrun, 1);
        sweep(4'hF, 8'hFF, 8'h44, 8'h84, 8'hC4, 2, 2);
        chk("ovr_set_wins", overrun, 1);
        clr_ovr = 1;
        step();
        clr_ovr = 0;
        chk("ovr_cleared", overrun, 0);
        // back-to-back sweeps against an accumulator model
        do_reset();
        incr = {16'h0F0F, 16'h0777, 16'h1357, 16'h2468};
        offset = 32'($urandom);
        for (int i = 0; i < NCH; i++) m_acc[i] = '0;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < NCH; i++) e[i] = m_acc[i][15:8] + offset[i*8 +: 8];
            sweep(4'hF, e[0], e[1], e[2], e[3], 0, 0);
            for (int i = 0; i < NCH; i++) m_acc[i] = m_acc[i] + incr[i*16 +: 16];
        end
        chk("soak_no_ovr", overrun, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
